// File: rtl/mem_dump_if.sv
// mem_dump_if: control, memory-read and byte-stream signals of the memory dump engine.
interface mem_dump_if #(parameter int ADDR_W = 8, parameter int DATA_W = 8);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   len;
    logic              busy;
    logic              done;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;
    modport slave (input start, start_addr, len, mem_data, out_ready,
                   output busy, done, mem_rd, mem_addr, out_data, out_valid, out_last);
    modport master (output start, start_addr, len, mem_data, out_ready,
                    input busy, done, mem_rd, mem_addr, out_data, out_valid, out_last);
endinterface

// File: rtl/mem_dump.sv
// mem_dump: streams len memory words from start_addr as a byte stream; MEM_DUMP_CHECKSUM_EN appends a sum byte.
module mem_dump #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic       clk,
    input  logic       rst,
    mem_dump_if.slave  io
);
`ifdef MEM_DUMP_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, FIN, CSUM} state_t;
    localparam state_t TAIL = CSUM;
`else
    typedef enum logic [2:0] {IDLE, READ, WAIT, SEND, FIN} state_t;
    localparam state_t TAIL = FIN;
`endif
    state_t            state, state_next;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W:0]   remaining;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              xfer;
    logic              final_word;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
`endif
    assign xfer       = out_valid & io.out_ready;
    assign final_word = remaining == (ADDR_W+1)'(1);
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = !io.start ? IDLE : io.len == '0 ? TAIL : READ;
            READ:    state_next = WAIT;
            WAIT:    state_next = SEND;
            SEND:    state_next = !xfer ? SEND : final_word ? TAIL : READ;
`ifdef MEM_DUMP_CHECKSUM_EN
            CSUM:    state_next = xfer ? FIN : CSUM;
`endif
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            addr      <= '0;
            remaining <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
            csum      <= '0;
`endif
        end else begin
            if (state == IDLE && io.start) begin
                addr      <= io.start_addr;
                remaining <= io.len;
            end
            if (state == WAIT) begin
                out_data  <= io.mem_data;
                out_valid <= 1'b1;
            end
            if (xfer) out_valid <= 1'b0;
            if (state == SEND && xfer) begin
                addr      <= addr + 1'b1;
                remaining <= remaining - 1'b1;
            end
`ifdef MEM_DUMP_CHECKSUM_EN
            if (state == IDLE && io.start) csum <= '0;
            if (state == WAIT) csum <= csum + io.mem_data;
            // csum already holds the final data byte, added when it left WAIT
            if (state != CSUM && state_next == CSUM) begin
                out_data  <= state == IDLE ? '0 : csum;
                out_valid <= 1'b1;
            end
`endif
        end
    end
    assign io.busy      = state != IDLE;
    assign io.done      = state == FIN;
    assign io.mem_rd    = state == READ;
    assign io.mem_addr  = addr;
    assign io.out_data  = out_data;
    assign io.out_valid = out_valid;
`ifdef MEM_DUMP_CHECKSUM_EN
    assign io.out_last  = out_valid && state == CSUM;
`else
    assign io.out_last  = out_valid && final_word;
`endif
endmodule
